id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline stage directly downstream of the register file. Captures reg1/reg2 read data and the decoded
//  controls. Forwards in-flight results from EX/MEM and MEM/WB over stale operands. Detects load-use hazards and
//  inserts a one-cycle bubble while stalling IF/ID. Presents a fully registered operand/control bundle to EX.
// PARAMETERS
//  DATA_W     32  operand / result width
//  REG_AW     5   register address width (32 GPRs, r0 hardwired zero)
//  ALU_CMD_W  4   ALU command field width
// PORTS
//  clk         in   1          clock; all state updates on posedge
//  rst         in   1          synchronous, active-high reset
//  idValid     in   1          ID holds a valid instruction
//  idSrc1      in   REG_AW     rs address (same as regFile src1)
//  idSrc2      in   REG_AW     rt address (same as regFile src2)
//  idDest      in   REG_AW     destination register
//  idReg1      in   DATA_W     regFile reg1 read data
//  idReg2      in   DATA_W     regFile reg2 read data
//  idImm       in   DATA_W     sign-extended immediate
//  idIsImm     in   1          operand 2 = immediate
//  idAluCmd    in   ALU_CMD_W  ALU command
//  idMemRead   in   1          load
//  idMemWrite  in   1          store
//  idWbEn      in   1          writes back to regFile
//  flush       in   1          branch taken; squash the ID instruction
//  freeze      in   1          downstream busy; hold all state
//  memDest     in   REG_AW     EX/MEM destination
//  memWbEn     in   1          EX/MEM write-back enable
//  memVal      in   DATA_W     EX/MEM ALU result
//  wbDest      in   REG_AW     MEM/WB destination (= regFile dest)
//  wbEn        in   1          MEM/WB write-back enable (= regFile writeEn)
//  wbVal       in   DATA_W     MEM/WB result (= regFile writeVal)
//  hazardStall out  1          combinational; hold PC and IF/ID this cycle
//  exValid     out  1          EX holds a real instruction
//  exVal1      out  DATA_W     ALU operand 1
//  exVal2      out  DATA_W     ALU operand 2 (immediate or forwarded rt)
//  exStVal     out  DATA_W     store data (forwarded rt)
//  exDest      out  REG_AW     destination register
//  exAluCmd    out  ALU_CMD_W  ALU command
//  exMemRead   out  1          load
//  exMemWrite  out  1          store
//  exWbEn      out  1          write-back enable
// BEHAVIOUR
//  - Reset: all ex* outputs 0. hazardStall is 0 while rst=1.
//  - Latency: 1 cycle. ID inputs sampled at posedge N appear on ex* after posedge N.
//  - Forwarding, per operand, using address a (idSrc1 or idSrc2):
//    - a==0 -> 0.
//    - Else memWbEn && memDest==a -> memVal.
//    - Else wbEn && wbDest==a -> wbVal.
//    - Else idReg1 / idReg2.
//    - EX/MEM beats MEM/WB when both match.
//  - exVal2 = idIsImm ? idImm : fwd2. exStVal = fwd2 always.
//  - Load-use: hazardStall = idValid & exValid & exMemRead & exDest!=0 & (exDest==idSrc1 | (exDest==idSrc2 & ~idIsImm))
//    - Exception: a store does count its rt (exDest==idSrc2 & idMemWrite) even when idIsImm=1.
//  - Update priority at posedge, highest first:
//    1. rst
//    2. freeze: hold every register; hazardStall still computed
//    3. flush: capture bubble
//    4. hazardStall: capture bubble; the ID instruction re-presents next cycle
//    5. normal capture
//  - Bubble: exValid, exMemRead, exMemWrite, exWbEn = 0; data/dest/cmd fields = 0.
//  - idValid=0 captures a bubble.
//  - Stall lasts exactly one cycle per load: after the bubble, exMemRead=0, so hazardStall falls.
//  - Back-to-back loads feeding each other: each dependent load gets its own single bubble.
//  - flush together with hazardStall: flush wins. hazardStall is still driven; the branch unit overrides IF.
//  - rst mid-stall: next cycle hazardStall=0 and ex* are cleared.
// STRUCTURE
//  - Shared include mips_defs.vh: DATA_W, REG_AW, ALU_CMD_W, REG_ZERO (5'd0), ALU command codes.
//  - Sub-module fwd_sel: combinational 3-source forwarding mux with r0 masking. Instantiated twice (rs, rt).
//  - Top level: hazard compare, priority next-state logic, output register bank.
// TESTING
//  - Reset: rst=1 for 2 cycles with random inputs -> all ex* = 0, hazardStall = 0.
//  - Capture: idSrc1=3, idReg1=0x11, idIsImm=1, idImm=0xFFFF_FFF0, no forwarding -> next cycle exVal1=0x11, exVal2=0xFFFF_FFF0, exValid=1.
//  - Forward priority: idSrc1=5, memDest=5/memVal=0xAA, wbDest=5/wbVal=0xBB, both enabled -> exVal1=0xAA. Drop memWbEn -> 0xBB.
//  - r0: idSrc2=0, memDest=0, memWbEn=1, memVal=0x55 -> exStVal=0.
//  - Load-use: lw r4 in EX, then add r6=r4+r2 in ID -> hazardStall=1 for one cycle, bubble in EX. The add is then captured with exVal1=memVal when memDest=4.
//  - Freeze/flush: freeze=1 for 3 cycles -> ex* unchanged. Flush with a valid ID instruction -> exValid=0, exWbEn=0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU command codes and the EX-side bundle type for the ID->EX stage.
package id_ex_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;
  localparam int ALU_CMD_W = 4;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [REG_AW-1:0]    reg_addr_t;
  typedef logic [ALU_CMD_W-1:0] alu_cmd_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic [ALU_CMD_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_LUI = 4'd9
  } alu_cmd_e;

  // Everything EX sees, held in one register bank so a bubble is a single '0.
  typedef struct packed {
    logic      valid;
    data_t     val1;
    data_t     val2;
    data_t     st_val;
    reg_addr_t dest;
    alu_cmd_t  alu_cmd;
    logic      mem_read;
    logic      mem_write;
    logic      wb_en;
  } ex_bundle_t;

  localparam ex_bundle_t EX_BUBBLE = '0;

  // A forwarding source hits when it is writing back to the operand's register.
  function automatic logic fwd_hit(input logic en, input reg_addr_t dest, input reg_addr_t src);
    return en && (dest == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, forwarding sources and registered EX-side outputs of the ID->EX stage.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic      idValid;
  reg_addr_t idSrc1;
  reg_addr_t idSrc2;
  reg_addr_t idDest;
  data_t     idReg1;
  data_t     idReg2;
  data_t     idImm;
  logic      idIsImm;
  alu_cmd_t  idAluCmd;
  logic      idMemRead;
  logic      idMemWrite;
  logic      idWbEn;
  logic      flush;
  logic      freeze;

  reg_addr_t memDest;
  logic      memWbEn;
  data_t     memVal;
  reg_addr_t wbDest;
  logic      wbEn;
  data_t     wbVal;

  logic      hazardStall;
  logic      exValid;
  data_t     exVal1;
  data_t     exVal2;
  data_t     exStVal;
  reg_addr_t exDest;
  alu_cmd_t  exAluCmd;
  logic      exMemRead;
  logic      exMemWrite;
  logic      exWbEn;

  modport master (
    output idValid, idSrc1, idSrc2, idDest, idReg1, idReg2, idImm, idIsImm,
           idAluCmd, idMemRead, idMemWrite, idWbEn, flush, freeze,
           memDest, memWbEn, memVal, wbDest, wbEn, wbVal,
    input  hazardStall, exValid, exVal1, exVal2, exStVal, exDest, exAluCmd,
           exMemRead, exMemWrite, exWbEn
  );

  modport slave (
    input  idValid, idSrc1, idSrc2, idDest, idReg1, idReg2, idImm, idIsImm,
           idAluCmd, idMemRead, idMemWrite, idWbEn, flush, freeze,
           memDest, memWbEn, memVal, wbDest, wbEn, wbVal,
    output hazardStall, exValid, exVal1, exVal2, exStVal, exDest, exAluCmd,
           exMemRead, exMemWrite, exWbEn
  );

endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Three-source operand select: EX/MEM result, then MEM/WB result, then register file; r0 always reads 0.
module id_ex_stage_fwd_sel
  import id_ex_stage_pkg::*;
(
  input  reg_addr_t src_i,
  input  data_t     reg_val_i,
  input  reg_addr_t mem_dest_i,
  input  logic      mem_wb_en_i,
  input  data_t     mem_val_i,
  input  reg_addr_t wb_dest_i,
  input  logic      wb_en_i,
  input  data_t     wb_val_i,
  output data_t     val_o
);

  // The youngest in-flight producer wins; r0 is masked even if a producer targets it.
  always_comb begin
    val_o = reg_val_i;
    if (src_i == REG_ZERO) begin
      val_o = '0;
    end else if (fwd_hit(mem_wb_en_i, mem_dest_i, src_i)) begin
      val_o = mem_val_i;
    end else if (fwd_hit(wb_en_i, wb_dest_i, src_i)) begin
      val_o = wb_val_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand forwarding and load-use bubble insertion.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  ex_bundle_t ex_q;
  ex_bundle_t ex_d;
  data_t      fwd1;
  data_t      fwd2;
  logic       rt_used;
  logic       load_in_ex;
  logic       src_match;
  logic       hazard_stall;

  id_ex_stage_fwd_sel u_fwd_rs (
    .src_i       (bus.idSrc1),
    .reg_val_i   (bus.idReg1),
    .mem_dest_i  (bus.memDest),
    .mem_wb_en_i (bus.memWbEn),
    .mem_val_i   (bus.memVal),
    .wb_dest_i   (bus.wbDest),
    .wb_en_i     (bus.wbEn),
    .wb_val_i    (bus.wbVal),
    .val_o       (fwd1)
  );

  id_ex_stage_fwd_sel u_fwd_rt (
    .src_i       (bus.idSrc2),
    .reg_val_i   (bus.idReg2),
    .mem_dest_i  (bus.memDest),
    .mem_wb_en_i (bus.memWbEn),
    .mem_val_i   (bus.memVal),
    .wb_dest_i   (bus.wbDest),
    .wb_en_i     (bus.wbEn),
    .wb_val_i    (bus.wbVal),
    .val_o       (fwd2)
  );

  // rt matters when it feeds the ALU, and for stores also when it is only the store data.
  assign rt_used    = ~bus.idIsImm | bus.idMemWrite;
  assign load_in_ex = ex_q.valid & ex_q.mem_read & (ex_q.dest != REG_ZERO);
  assign src_match  = (ex_q.dest == bus.idSrc1) | ((ex_q.dest == bus.idSrc2) & rt_used);

  // Gated by rst so IF is never held while the pipeline is being cleared.
  assign hazard_stall    = ~rst & bus.idValid & load_in_ex & src_match;
  assign bus.hazardStall = hazard_stall;

  // Next EX contents: hold on freeze, bubble on flush/stall/empty ID, else capture ID.
  always_comb begin
    ex_d = ex_q;
    if (bus.freeze) begin
      ex_d = ex_q;
    end else if (bus.flush || hazard_stall || !bus.idValid) begin
      ex_d = EX_BUBBLE;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.val1      = fwd1;
      ex_d.val2      = bus.idIsImm ? bus.idImm : fwd2;
      ex_d.st_val    = fwd2;
      ex_d.dest      = bus.idDest;
      ex_d.alu_cmd   = bus.idAluCmd;
      ex_d.mem_read  = bus.idMemRead;
      ex_d.mem_write = bus.idMemWrite;
      ex_d.wb_en     = bus.idWbEn;
    end
  end

  // EX register bank; synchronous reset to an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.exValid    = ex_q.valid;
  assign bus.exVal1     = ex_q.val1;
  assign bus.exVal2     = ex_q.val2;
  assign bus.exStVal    = ex_q.st_val;
  assign bus.exDest     = ex_q.dest;
  assign bus.exAluCmd   = ex_q.alu_cmd;
  assign bus.exMemRead  = ex_q.mem_read;
  assign bus.exMemWrite = ex_q.mem_write;
  assign bus.exWbEn     = ex_q.wb_en;

endmodule
